// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen shared types and constants.
// Default widths, tap count, FSM states.
package conv_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int KER_W_DEF = 4;
  localparam int NTAP      = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // msb of tap k (1..NTAP) in a packed kernel word
  function automatic int tap_hi(input int k, input int w);
    return k * w - 1;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle of conv_window_gen.
// master = stream source and window sink, slave = the generator.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int KER_W = KER_W_DEF
) ();

  logic                    i_valid;
  logic [PIX_W-1:0]        i_pix;
  logic                    i_sof;
  logic                    o_ready;
  logic                    i_inhibit;
  logic                    i_ker_load;
  logic [NTAP*KER_W-1:0]   i_ker;
  logic                    o_valid;
  logic                    o_last;
  logic [PIX_W-1:0]        o_im1, o_im2, o_im3;
  logic [PIX_W-1:0]        o_im4, o_im5, o_im6;
  logic [PIX_W-1:0]        o_im7, o_im8, o_im9;
  logic [KER_W-1:0]        o_ker1, o_ker2, o_ker3;
  logic [KER_W-1:0]        o_ker4, o_ker5, o_ker6;
  logic [KER_W-1:0]        o_ker7, o_ker8, o_ker9;

  modport master (
    output i_valid, i_pix, i_sof, i_inhibit,
    output i_ker_load, i_ker,
    input  o_ready, o_valid, o_last,
    input  o_im1, o_im2, o_im3, o_im4, o_im5,
    input  o_im6, o_im7, o_im8, o_im9,
    input  o_ker1, o_ker2, o_ker3, o_ker4, o_ker5,
    input  o_ker6, o_ker7, o_ker8, o_ker9
  );

  modport slave (
    input  i_valid, i_pix, i_sof, i_inhibit,
    input  i_ker_load, i_ker,
    output o_ready, o_valid, o_last,
    output o_im1, o_im2, o_im3, o_im4, o_im5,
    output o_im6, o_im7, o_im8, o_im9,
    output o_ker1, o_ker2, o_ker3, o_ker4, o_ker5,
    output o_ker6, o_ker7, o_ker8, o_ker9
  );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of delay: shift-enable register FIFO.
// dout is the word pushed DEPTH accepted shifts ago.
module line_buffer #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // contents are refilled before use, so no reset
  always_ff @(posedge clk) begin
    if (en) mem <= {mem[DEPTH-2:0], din};
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator feeding mac.
// Two row delays, three column shifters, kernel latch.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = PIX_W_DEF,
  parameter int KER_W = KER_W_DEF
) (
  input  logic clk,
  input  logic i_rst,
  conv_window_gen_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic                  acc;
  logic [CW-1:0]         col_q, col_n;
  logic [RW-1:0]         row_q, row_n;
  state_t                state_q, state_n;
  logic                  valid_d, last_d;
  logic                  valid_q, last_q;
  logic [PIX_W-1:0]      lb0_q, lb1_q;
  logic [2:0][PIX_W-1:0] w_top, w_mid, w_bot;
  logic [NTAP*KER_W-1:0] ker_q;

  assign bus.o_ready = ~bus.i_inhibit & ~i_rst;
  assign acc = bus.i_valid & bus.o_ready;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk  (clk),
    .en   (acc),
    .din  (bus.i_pix),
    .dout (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk  (clk),
    .en   (acc),
    .din  (lb0_q),
    .dout (lb1_q)
  );

  // raster position after the pixel being accepted
  always_comb begin
    col_n = col_q;
    row_n = row_q;
    if (bus.i_sof) begin
      col_n = CW'(1);
      row_n = '0;
    end else if (col_q == COL_MAX) begin
      col_n = '0;
      row_n = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
    end else begin
      col_n = col_q + CW'(1);
    end
  end

  // next state and window flags; a sof pixel is (0,0)
  always_comb begin
    state_n = state_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) state_n = PRIME;
      end
      PRIME: begin
        if (acc && row_n >= RW'(2)) state_n = STREAM;
      end
      STREAM: begin
        if (acc && row_n < RW'(2)) state_n = PRIME;
        valid_d = acc & ~bus.i_sof & (col_q >= CW'(2));
        last_d  = valid_d & (row_q == ROW_MAX)
                & (col_q == COL_MAX);
      end
      default: state_n = IDLE;
    endcase
  end

  // position counters and FSM state advance on accept
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= IDLE;
    end else if (acc) begin
      col_q   <= col_n;
      row_q   <= row_n;
      state_q <= state_n;
    end
  end

  // output strobes live for exactly one cycle
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // column shifters; index 0 is column c
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      w_top <= '0;
      w_mid <= '0;
      w_bot <= '0;
    end else if (acc) begin
      w_top <= {w_top[1:0], lb1_q};
      w_mid <= {w_mid[1:0], lb0_q};
      w_bot <= {w_bot[1:0], bus.i_pix};
    end
  end

  // kernel latch ignores the stall
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) ker_q <= '0;
    else if (bus.i_ker_load) ker_q <= bus.i_ker;
  end

  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;

  assign bus.o_im1 = w_top[2];
  assign bus.o_im2 = w_top[1];
  assign bus.o_im3 = w_top[0];
  assign bus.o_im4 = w_mid[2];
  assign bus.o_im5 = w_mid[1];
  assign bus.o_im6 = w_mid[0];
  assign bus.o_im7 = w_bot[2];
  assign bus.o_im8 = w_bot[1];
  assign bus.o_im9 = w_bot[0];

  assign bus.o_ker1 = ker_q[tap_hi(1, KER_W) -: KER_W];
  assign bus.o_ker2 = ker_q[tap_hi(2, KER_W) -: KER_W];
  assign bus.o_ker3 = ker_q[tap_hi(3, KER_W) -: KER_W];
  assign bus.o_ker4 = ker_q[tap_hi(4, KER_W) -: KER_W];
  assign bus.o_ker5 = ker_q[tap_hi(5, KER_W) -: KER_W];
  assign bus.o_ker6 = ker_q[tap_hi(6, KER_W) -: KER_W];
  assign bus.o_ker7 = ker_q[tap_hi(7, KER_W) -: KER_W];
  assign bus.o_ker8 = ker_q[tap_hi(8, KER_W) -: KER_W];
  assign bus.o_ker9 = ker_q[tap_hi(9, KER_W) -: KER_W];

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that sits directly upstream of `mac`. It accepts a raster-order 8-bit pixel stream, buffers the two previous image rows, and emits one 3x3 pixel window per accepted pixel once the window is complete. Each window is paired with the current 4-bit kernel and a one-cycle `o_valid`, so `mac` can consume windows back-to-back. It replaces bench-side row-delay logic with a frame-aware, stallable hardware stage.

## Interface
- `IMG_W`, 128, pixels per image row (≥3)
- `IMG_H`, 128, rows per frame (≥3)
- `PIX_W`, 8, pixel width
- `KER_W`, 4, kernel tap width
---
- `clk`  in  1  single clock, rising edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_valid`  in  1  pixel present on `i_pix`
- `i_pix`  in  PIX_W  raster-order pixel
- `i_sof`  in  1  qualifies `i_pix` as pixel (0,0); resynchronises counters
- `o_ready`  out  1  pixel accepted when `i_valid && o_ready`
- `i_inhibit`  in  1  downstream stall
- `i_ker_load`  in  1  latch `i_ker`
- `i_ker`  in  9*KER_W  taps; tap k (1..9) = bits [k*KER_W-1 -: KER_W]
- `o_valid`  out  1  window valid, one cycle per window
- `o_im1`..`o_im9`  out  PIX_W each  window; 1-3 row r-2, 4-6 row r-1, 7-9 row r; within each triple, columns c-2, c-1, c
- `o_ker1`..`o_ker9`  out  KER_W each  kernel taps
- `o_last`  out  1  with `o_valid`: last window of frame

## Operation
- `o_ready = ~i_inhibit & ~i_rst` (combinational).
- Accept: `acc = i_valid & o_ready`. Otherwise every register holds.
- Counters: `col` 0..IMG_W-1 and `row` 0..IMG_H-1. On `acc`, col++; at IMG_W-1, col wraps to 0 and row++. At (IMG_H-1, IMG_W-1), both counters wrap to 0.
- `acc && i_sof` treats the pixel as (0,0) and sets next col=1, row=0, regardless of the old counters. Window registers are not cleared.
- Line buffers: two IMG_W-deep, PIX_W-wide FIFOs in cascade. On `acc`, `i_pix` enters LB0 and LB0 output enters LB1; the outputs are the pixels at (r-1,c) and (r-2,c).
- Window: three 3-deep column shift registers, loaded on `acc` with {LB1 out, LB0 out, i_pix}.
- FSM:
  - IDLE: after reset; first `acc` → PRIME.
  - PRIME: row<2.
  - STREAM: row≥2.
  - STREAM→PRIME on frame wrap or on `i_sof`.
- `o_valid` is registered: set on the edge of an `acc` where the FSM is STREAM (or the pixel takes row to 2) and col≥2; cleared on any other edge.
- `o_last` is registered: set together with `o_valid` when the accepted pixel is (IMG_H-1, IMG_W-1).
- Kernel: on `i_ker_load`, the `o_ker` register loads `i_ker`. A load is independent of `i_inhibit`. A load on the same edge as a window pairs that window with the new kernel.

## Timing
- Latency: pixel (r,c) accepted at edge t → `o_valid` high after edge t, for exactly one cycle. The window is centred on (r-1,c-1).
- Throughput: one window per cycle in STREAM; (IMG_W-2)·(IMG_H-2) windows per frame.
- Inhibit: while `i_inhibit`=1, no pixel is accepted, `o_valid`=0, and window and counters hold.
- Reset (any time, including mid-frame): all outputs 0, FSM IDLE, counters 0. Line buffer contents are don't-care (never observed before refill).
- Column wrap: windows do not span rows; col 0 and col 1 of each row produce no `o_valid`.

## Structure
- Package `conv_pkg`: PIX_W=8, KER_W=4, NTAP=9, FSM state enum {IDLE, PRIME, STREAM}, tap-slice helper constants.
- Sub-module `line_buffer` (param DEPTH, WIDTH; shift-enable FIFO, register or single-port RAM). Instantiated twice.
- Top: counters, FSM, window shift registers, kernel register, output regs (≈200 lines).

## Test plan
- IMG_W=4, IMG_H=4, pixels 0..15, i_valid continuous → 4 windows. First window (after pixel 10) = {0,1,2,4,5,6,8,9,10}. Last window = {5,6,7,9,10,11,13,14,15} with `o_last`=1.
- Same stream with `i_inhibit`=1 for 3 cycles at pixel 11 → `o_ready`=0 and `o_valid`=0 during the stall. Window contents are identical to the unstalled run.
- `i_ker_load` with taps 1..9 on the same edge as the first window → that window shows `o_ker1`=1…`o_ker9`=9. Earlier `o_ker` values are 0.
- Reset asserted after pixel 9 of frame 1, then pixels 0..15 replayed → no `o_valid` before the new pixel 10; windows match the first scenario.
- `i_sof` on the 7th pixel of a frame (mid-frame) → counters resync; next `o_valid` occurs only after 10 more pixels.
- IMG_W=128, IMG_H=3, random pixels → 126 windows; all windows match a reference model; exactly one `o_last`.
